// File: rtl/demux_1to4_if.sv
// Stream bus between an upstream producer, the 1:4 demux and its four consumers.
// The master side belongs to whoever drives words in and pops channels.
// The slave side is the demultiplexer itself.
interface demux_1to4_if #(
    parameter int n = 8
);
    logic [n-1:0] d;
    logic [1:0]   sel;
    logic         en;
    logic         in_valid;
    logic         in_ready;
    logic [n-1:0] q0;
    logic [n-1:0] q1;
    logic [n-1:0] q2;
    logic [n-1:0] q3;
    logic [3:0]   q_valid;
    logic [3:0]   q_ready;

    modport master (
        output d, sel, en, in_valid, q_ready,
        input  in_ready, q0, q1, q2, q3, q_valid
    );

    modport slave (
        input  d, sel, en, in_valid, q_ready,
        output in_ready, q0, q1, q2, q3, q_valid
    );
endinterface

// File: rtl/demux_1to4.sv
// Registered 1:4 stream demultiplexer.
// Each incoming word is routed by sel into one of four one-entry holding
// registers. Every channel has its own valid/ready handshake toward its consumer.
// A full channel stalls only words aimed at that channel. A channel that is
// popped in the same cycle it is pushed passes one word per cycle.
module demux_1to4 #(
    parameter int n = 8
) (
    input  logic              clk,
    input  logic              rst,
    demux_1to4_if.slave       bus
);

    logic [n-1:0] qData_q [4];
    logic [n-1:0] qData_d [4];
    logic [3:0]   qValid_q;
    logic [3:0]   qValid_d;
    logic         inReady;
    logic         push;
    logic [3:0]   pop;

    // Accept a word only when the selected channel is empty or is being drained this cycle.
    always_comb begin
        inReady = ~rst & bus.en & (~qValid_q[bus.sel] | bus.q_ready[bus.sel]);
        push    = bus.in_valid & inReady;
        pop     = qValid_q & bus.q_ready;
    end

    // Per-channel next state: a pop clears valid, a push refills it and overrides the pop.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            qData_d[i]  = qData_q[i];
            qValid_d[i] = qValid_q[i] & ~pop[i];
            if (push && (bus.sel == 2'(i))) begin
                qData_d[i]  = bus.d;
                qValid_d[i] = 1'b1;
            end
        end
    end

    // Channel registers; reset drops every held word and clears the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                qData_q[i] <= '0;
            end
            qValid_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                qData_q[i] <= qData_d[i];
            end
            qValid_q <= qValid_d;
        end
    end

    assign bus.in_ready = inReady;
    assign bus.q0       = qData_q[0];
    assign bus.q1       = qData_q[1];
    assign bus.q2       = qData_q[2];
    assign bus.q3       = qData_q[3];
    assign bus.q_valid  = qValid_q;

endmodule

// File: tb/tb_demux_1to4.sv
// Directed bench for the 1:4 stream demultiplexer.
// Inputs change 1 ns after each rising edge. Outputs are sampled there or after a short settle.
module tb_demux_1to4;

    logic clk;
    logic rst;
    int   testsRun;
    int   testsFailed;

    demux_1to4_if #(.n(8)) bus ();

    demux_1to4 #(.n(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs [4];
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 2'd0;
        bus.d        = 8'hFF;
        bus.q_ready  = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            #1;
            testsRun++;
            if (bus.in_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_in_ready cycle %0d: got %b expected 0", c, bus.in_ready);
            end
            tick();
            testsRun++;
            if (bus.q_valid !== 4'b0000) begin
                testsFailed++;
                $display("[TB] FAIL reset_q_valid cycle %0d: got %b expected 0000", c, bus.q_valid);
            end
            obs = '{bus.q0, bus.q1, bus.q2, bus.q3};
            for (int i = 0; i < 4; i++) begin
                testsRun++;
                if (obs[i] !== 8'h00) begin
                    testsFailed++;
                    $display("[TB] FAIL reset_q%0d: got %h expected 00", i, obs[i]);
                end
            end
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_routing();
        logic [7:0] obs [4];
        logic [7:0] exp [4];
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        bus.en       = 1'b1;
        bus.q_ready  = 4'b0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(i);
            bus.d   = exp[i];
            #1;
            testsRun++;
            if (bus.in_ready !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL routing_in_ready sel %0d: got %b expected 1", i, bus.in_ready);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        obs = '{bus.q0, bus.q1, bus.q2, bus.q3};
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obs[i] !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL routing_q%0d: got %h expected %h", i, obs[i], exp[i]);
            end
        end
        testsRun++;
        if (bus.q_valid !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL routing_q_valid: got %b expected 1111", bus.q_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] obs [4];
        logic [7:0] exp [4];
        bus.sel      = 2'd2;
        bus.d        = 8'h55;
        bus.in_valid = 1'b1;
        bus.q_ready  = 4'b0000;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_full_in_ready: got %b expected 0", bus.in_ready);
        end
        tick();
        testsRun++;
        if (bus.q2 !== 8'hA2) begin
            testsFailed++;
            $display("[TB] FAIL bp_q2_held: got %h expected a2", bus.q2);
        end
        testsRun++;
        if (bus.q_valid !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL bp_q_valid_held: got %b expected 1111", bus.q_valid);
        end
        bus.q_ready = 4'b0100;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_release_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.q_ready  = 4'b0000;
        exp = '{8'hA0, 8'hA1, 8'h55, 8'hA3};
        obs = '{bus.q0, bus.q1, bus.q2, bus.q3};
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obs[i] !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL bp_after_q%0d: got %h expected %h", i, obs[i], exp[i]);
            end
        end
        testsRun++;
        if (bus.q_valid !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL bp_after_q_valid: got %b expected 1111", bus.q_valid);
        end
    endtask

    task automatic test_throughput();
        logic [7:0] word;
        bus.sel      = 2'd1;
        bus.q_ready  = 4'b0010;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            word  = 8'(k);
            bus.d = word;
            #1;
            testsRun++;
            if (bus.in_ready !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL tput_in_ready word %0d: got %b expected 1", k, bus.in_ready);
            end
            tick();
            testsRun++;
            if ((bus.q1 !== word) || (bus.q_valid !== 4'b1111)) begin
                testsFailed++;
                $display("[TB] FAIL tput_q1 word %0d: got q1=%h q_valid=%b expected q1=%h q_valid=1111",
                         k, bus.q1, bus.q_valid, word);
            end
        end
        bus.in_valid = 1'b0;
        bus.q_ready  = 4'b0000;
    endtask

    task automatic test_enable();
        logic [7:0] obs [4];
        logic [7:0] exp [4];
        bus.en       = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 2'd0;
        bus.d        = 8'h33;
        bus.q_ready  = 4'b1111;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL enable_in_ready: got %b expected 0", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        bus.q_ready  = 4'b0000;
        testsRun++;
        if (bus.q_valid !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL enable_q_valid: got %b expected 0000", bus.q_valid);
        end
        exp = '{8'hA0, 8'hFF, 8'h55, 8'hA3};
        obs = '{bus.q0, bus.q1, bus.q2, bus.q3};
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obs[i] !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL enable_q%0d: got %h expected %h", i, obs[i], exp[i]);
            end
        end
        bus.en = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] obs [4];
        logic [7:0] exp [4];
        logic [1:0] selSeq [3];
        logic [7:0] dSeq [3];
        selSeq = '{2'd0, 2'd1, 2'd3};
        dSeq   = '{8'h11, 8'h22, 8'h44};
        bus.en       = 1'b1;
        bus.q_ready  = 4'b0000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.sel = selSeq[i];
            bus.d   = dSeq[i];
            tick();
        end
        bus.in_valid = 1'b0;
        testsRun++;
        if (bus.q_valid !== 4'b1011) begin
            testsFailed++;
            $display("[TB] FAIL mid_setup_q_valid: got %b expected 1011", bus.q_valid);
        end
        rst          = 1'b1;
        bus.sel      = 2'd2;
        bus.d        = 8'h99;
        bus.in_valid = 1'b1;
        #1;
        testsRun++;
        if (bus.in_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mid_rst_in_ready: got %b expected 0", bus.in_ready);
        end
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        testsRun++;
        if (bus.q_valid !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL mid_rst_q_valid: got %b expected 0000", bus.q_valid);
        end
        obs = '{bus.q0, bus.q1, bus.q2, bus.q3};
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obs[i] !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL mid_rst_q%0d: got %h expected 00", i, obs[i]);
            end
        end
        bus.sel      = 2'd2;
        bus.d        = 8'h7E;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp = '{8'h00, 8'h00, 8'h7E, 8'h00};
        obs = '{bus.q0, bus.q1, bus.q2, bus.q3};
        for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (obs[i] !== exp[i]) begin
                testsFailed++;
                $display("[TB] FAIL mid_push_q%0d: got %h expected %h", i, obs[i], exp[i]);
            end
        end
        testsRun++;
        if (bus.q_valid !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL mid_push_q_valid: got %b expected 0100", bus.q_valid);
        end
    endtask

    // Scenario sequence; each task leaves the state the next one starts from.
    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        rst          = 1'b1;
        bus.d        = 8'h00;
        bus.sel      = 2'd0;
        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.q_ready  = 4'b0000;
        test_reset();
        test_routing();
        test_backpressure();
        test_throughput();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
